// File: rtl/cluster_icache_flush_sequencer.sv
// Icache flush responder: drains refills, pulses L0 flushes, then walks every L1 set to invalidate it.
// Optional cycle counter output enabled by defining CLUSTER_ICACHE_FLUSH_PERF_EN.
module cluster_icache_flush_sequencer #(
    parameter int NR_FETCH_PORTS = 1,
    parameter int SET_COUNT      = 128,
    parameter int SET_AW         = $clog2(SET_COUNT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NR_FETCH_PORTS-1:0] flush_valid_i,
    output logic [NR_FETCH_PORTS-1:0] flush_ready_o,
    input  logic                      refill_idle_i,
    output logic                      lookup_block_o,
    output logic [NR_FETCH_PORTS-1:0] l0_flush_o,
    input  logic [NR_FETCH_PORTS-1:0] l0_flush_ack_i,
    output logic                      tag_req_o,
    input  logic                      tag_gnt_i,
    output logic [SET_AW-1:0]         tag_addr_o,
    output logic                      flush_busy_o
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
   ,output logic [31:0]               flush_cycles_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_L0,
        S_WALK,
        S_DONE
    } state_e;

    localparam logic [SET_AW-1:0] LAST_SET = SET_AW'(SET_COUNT - 1);

    state_e                    state, state_n;
    logic [NR_FETCH_PORTS-1:0] pending, pending_n;
    logic [NR_FETCH_PORTS-1:0] active, active_n;
    logic [NR_FETCH_PORTS-1:0] ack_mask, ack_mask_n;
    logic [NR_FETCH_PORTS-1:0] l0_flush_n;
    logic [SET_AW-1:0]         set_cnt, set_cnt_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // New requests always land in pending; active is only loaded from IDLE so a walk
    // in progress never claims to cover a port that asked after it started.
    always_comb begin
        state_n    = state;
        pending_n  = pending | flush_valid_i;
        active_n   = active;
        ack_mask_n = ack_mask;
        set_cnt_n  = set_cnt;
        l0_flush_n = '0;
        case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    active_n  = pending;
                    pending_n = flush_valid_i;
                    state_n   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (refill_idle_i) begin
                    l0_flush_n = active;
                    ack_mask_n = ~active;
                    state_n    = S_L0;
                end
            end
            S_L0: begin
                ack_mask_n = ack_mask | l0_flush_ack_i;
                if (&(ack_mask | l0_flush_ack_i)) begin
                    set_cnt_n = '0;
                    state_n   = S_WALK;
                end
            end
            S_WALK: begin
                if (tag_gnt_i) begin
                    if (set_cnt == LAST_SET) begin
                        set_cnt_n = '0;
                        state_n   = S_DONE;
                    end else begin
                        set_cnt_n = set_cnt + 1'b1;
                    end
                end
            end
            S_DONE: begin
                active_n = '0;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending       <= '0;
            active        <= '0;
            ack_mask      <= '0;
            set_cnt       <= '0;
            l0_flush_o    <= '0;
            flush_ready_o <= '1;
        end else begin
            pending       <= pending_n;
            active        <= active_n;
            ack_mask      <= ack_mask_n;
            set_cnt       <= set_cnt_n;
            l0_flush_o    <= l0_flush_n;
            flush_ready_o <= ~(pending_n | active_n);
        end
    end

    assign lookup_block_o = (state != S_IDLE);
    assign flush_busy_o   = (state != S_IDLE);
    assign tag_req_o      = (state == S_WALK);
    assign tag_addr_o     = set_cnt;

`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
    logic [31:0] perf_cnt;

    // The reported figure includes the DONE cycle itself, hence the +1 on capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cnt       <= '0;
            flush_cycles_o <= '0;
        end else begin
            if (state == S_IDLE) begin
                if (state_n != S_IDLE) begin
                    perf_cnt <= '0;
                end
            end else if (perf_cnt != 32'hFFFF_FFFF) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (state == S_DONE) begin
                flush_cycles_o <= (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cluster_icache_flush_sequencer.sv
// Directed bench for cluster_icache_flush_sequencer with 2 ports and 4 sets.
// Checks flush_cycles_o too when CLUSTER_ICACHE_FLUSH_PERF_EN is defined.
module tb_cluster_icache_flush_sequencer;

    localparam int NP = 2;
    localparam int SC = 4;
    localparam int AW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NP-1:0] flush_valid_i;
    logic [NP-1:0] flush_ready_o;
    logic          refill_idle_i;
    logic          lookup_block_o;
    logic [NP-1:0] l0_flush_o;
    logic [NP-1:0] l0_flush_ack_i;
    logic          tag_req_o;
    logic          tag_gnt_i;
    logic [AW-1:0] tag_addr_o;
    logic          flush_busy_o;
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
    logic [31:0]   flush_cycles_o;
`endif

    int total      = 0;
    int bad        = 0;
    int ready0_low = 0;
    int ready1_low = 0;
    int gnt_total  = 0;
    int seq_bad    = 0;
    int g0         = 0;
    logic [AW-1:0] exp_addr = '0;

    cluster_icache_flush_sequencer #(
        .NR_FETCH_PORTS(NP),
        .SET_COUNT     (SC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_valid_i (flush_valid_i),
        .flush_ready_o (flush_ready_o),
        .refill_idle_i (refill_idle_i),
        .lookup_block_o(lookup_block_o),
        .l0_flush_o    (l0_flush_o),
        .l0_flush_ack_i(l0_flush_ack_i),
        .tag_req_o     (tag_req_o),
        .tag_gnt_i     (tag_gnt_i),
        .tag_addr_o    (tag_addr_o),
        .flush_busy_o  (flush_busy_o)
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
       ,.flush_cycles_o(flush_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Every accepted tag request must address the set after the previous one.
    always @(posedge clk_i) begin
        if (tag_req_o && tag_gnt_i) begin
            gnt_total <= gnt_total + 1;
            if (tag_addr_o !== exp_addr) seq_bad <= seq_bad + 1;
            exp_addr <= tag_addr_o + 1'b1;
        end else if (!tag_req_o) begin
            exp_addr <= '0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk_i);
        if (flush_ready_o[0] == 1'b0) ready0_low++;
        if (flush_ready_o[1] == 1'b0) ready1_low++;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] v, input logic idle,
                                 input logic [NP-1:0] ack, input logic g);
        flush_valid_i  = v;
        refill_idle_i  = idle;
        l0_flush_ack_i = ack;
        tag_gnt_i      = g;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready"}, 32'(flush_ready_o), 32'h3);
        checkOutput({tag, "_busy"}, 32'(flush_busy_o), 32'h0);
        checkOutput({tag, "_block"}, 32'(lookup_block_o), 32'h0);
        checkOutput({tag, "_l0"}, 32'(l0_flush_o), 32'h0);
        checkOutput({tag, "_req"}, 32'(tag_req_o), 32'h0);
    endtask

    task automatic serveL0(input string tag, input logic [NP-1:0] ports);
        checkOutput({tag, "_l0"}, 32'(l0_flush_o), 32'(ports));
        checkOutput({tag, "_l0_req"}, 32'(tag_req_o), 32'h0);
        applyStimulus('0, 1'b1, ports, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
    endtask

    task automatic walkAll(input string tag);
        for (int i = 0; i < SC; i++) begin
            checkOutput({tag, "_walk_req"}, 32'(tag_req_o), 32'h1);
            checkOutput({tag, "_walk_addr"}, 32'(tag_addr_o), 32'(i));
            tick();
        end
        checkOutput({tag, "_done_req"}, 32'(tag_req_o), 32'h0);
        checkOutput({tag, "_done_busy"}, 32'(flush_busy_o), 32'h1);
        tick();
    endtask

    initial begin
        applyStimulus('0, 1'b1, '0, 1'b1);
        rst_i = 1'b1;
        #1;
        checkIdle("reset");
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Single pulse on port 0, ack one cycle after the L0 pulse, grant always high.
        applyStimulus(2'b01, 1'b1, '0, 1'b1);
        ready0_low = 0;
        ready1_low = 0;
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        checkOutput("s1_ready_fall", 32'(flush_ready_o), 32'h2);
        checkOutput("s1_busy_idle", 32'(flush_busy_o), 32'h0);
        tick();
        checkOutput("s1_drain_busy", 32'(flush_busy_o), 32'h1);
        checkOutput("s1_drain_block", 32'(lookup_block_o), 32'h1);
        checkOutput("s1_drain_l0", 32'(l0_flush_o), 32'h0);
        tick();
        checkOutput("s1_l0_pulse", 32'(l0_flush_o), 32'h1);
        checkOutput("s1_l0_req", 32'(tag_req_o), 32'h0);
        tick();
        checkOutput("s1_l0_pulse_end", 32'(l0_flush_o), 32'h0);
        checkOutput("s1_l0_wait_req", 32'(tag_req_o), 32'h0);
        applyStimulus('0, 1'b1, 2'b01, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        walkAll("s1");
        checkIdle("s1_end");
        checkOutput("s1_ready0_low_cycles", 32'(ready0_low), 32'd9);
        checkOutput("s1_ready1_low_cycles", 32'(ready1_low), 32'd0);
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
        checkOutput("s1_perf_cycles", flush_cycles_o, 32'd8);
`endif

        // Refills outstanding: the sequencer must sit in DRAIN.
        applyStimulus(2'b01, 1'b0, '0, 1'b1);
        tick();
        applyStimulus('0, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < 9; i++) begin
            checkOutput("s2_drain_busy", 32'(flush_busy_o), 32'h1);
            checkOutput("s2_drain_block", 32'(lookup_block_o), 32'h1);
            checkOutput("s2_drain_l0", 32'(l0_flush_o), 32'h0);
            checkOutput("s2_drain_req", 32'(tag_req_o), 32'h0);
            tick();
        end
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
        checkOutput("s2_perf_hold", flush_cycles_o, 32'd8);
`endif
        applyStimulus('0, 1'b1, '0, 1'b1);
        tick();
        serveL0("s2", 2'b01);
        walkAll("s2");
        checkIdle("s2_end");

        // Grant withheld for three cycles on set 2.
        g0 = gnt_total;
        applyStimulus(2'b01, 1'b1, '0, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        tick();
        tick();
        serveL0("s3", 2'b01);
        checkOutput("s3_addr0", 32'(tag_addr_o), 32'd0);
        tick();
        checkOutput("s3_addr1", 32'(tag_addr_o), 32'd1);
        tick();
        checkOutput("s3_addr2", 32'(tag_addr_o), 32'd2);
        applyStimulus('0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("s3_stall_req", 32'(tag_req_o), 32'h1);
            checkOutput("s3_stall_addr", 32'(tag_addr_o), 32'd2);
        end
        applyStimulus('0, 1'b1, '0, 1'b1);
        tick();
        checkOutput("s3_addr3", 32'(tag_addr_o), 32'd3);
        tick();
        checkOutput("s3_done_req", 32'(tag_req_o), 32'h0);
        tick();
        checkIdle("s3_end");
        checkOutput("s3_grant_count", 32'(gnt_total - g0), 32'd4);

        // Port 1 asks during port 0's walk and gets its own later round.
        applyStimulus(2'b01, 1'b1, '0, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        tick();
        tick();
        serveL0("s4a", 2'b01);
        tick();
        checkOutput("s4_addr1", 32'(tag_addr_o), 32'd1);
        applyStimulus(2'b10, 1'b1, '0, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        checkOutput("s4_ready_both_low", 32'(flush_ready_o), 32'h0);
        checkOutput("s4_addr2", 32'(tag_addr_o), 32'd2);
        tick();
        tick();
        checkOutput("s4_done_ready", 32'(flush_ready_o), 32'h0);
        checkOutput("s4_done_busy", 32'(flush_busy_o), 32'h1);
        tick();
        checkOutput("s4_release_port0", 32'(flush_ready_o), 32'h1);
        checkOutput("s4_idle_gap", 32'(flush_busy_o), 32'h0);
        tick();
        checkOutput("s4_round2_busy", 32'(flush_busy_o), 32'h1);
        checkOutput("s4_round2_ready", 32'(flush_ready_o), 32'h1);
        tick();
        serveL0("s4b", 2'b10);
        walkAll("s4b");
        checkIdle("s4_end");

        // Both ports together, then reset in the middle of the walk.
        applyStimulus(2'b11, 1'b1, '0, 1'b1);
        tick();
        applyStimulus('0, 1'b1, '0, 1'b1);
        checkOutput("s5_ready_both", 32'(flush_ready_o), 32'h0);
        tick();
        tick();
        serveL0("s5", 2'b11);
        tick();
        checkOutput("s5_addr1", 32'(tag_addr_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkIdle("s5_async_rst");
        checkOutput("s5_rst_addr", 32'(tag_addr_o), 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkIdle("s5_post_rst");
        end
`ifdef CLUSTER_ICACHE_FLUSH_PERF_EN
        checkOutput("s5_perf_rst", flush_cycles_o, 32'd0);
`endif
        checkOutput("set_sequence_errors", 32'(seq_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
